stream_packer: RTL and testbench

Parametrised successor to the keep-mask compactor in the normalization library. It removes keep-deasserted elements from each input beat and repacks the survivors across beat boundaries, so only fully populated output beats leave the block. The exception is the final beat of a packet, which flushes a partial beat on `last`. It has full valid/ready backpressure and sits between filter/selection stages and width-sensitive consumers.

---
 rtl/stream_packer_pkg.sv | 34 +++
 rtl/stream_packer_if.sv | 14 +
 rtl/stream_packer_compact_stage.sv | 56 +++++
 rtl/stream_packer.sv | 142 ++++++++++++++
 tb/tb_stream_packer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/stream_packer_pkg.sv
// Shared helpers for stream_packer: count widths, register placement in the
// compaction pipeline, and the stage record layout for the default build.
package stream_packer_pkg;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int reg_levels(input int n, input int l);
    if (l < 0) return 0;
    return (l > n) ? n : l;
  endfunction

  // Level spacing between registers; n+1 means no level is registered.
  function automatic int reg_gap(input int n, input int l);
    int le;
    le = reg_levels(n, l);
    return (le == 0) ? n + 1 : (n + le - 1) / le;
  endfunction

  function automatic bit level_registered(input int n, input int l, input int lvl);
    return ((lvl + 1) % reg_gap(n, l)) == 0;
  endfunction

  // Stage record for 4 x 8-bit elements; wider builds declare the same layout.
  typedef struct packed {
    logic [3:0][7:0] data;
    logic [3:0]      keep;
    logic [2:0]      count;
    logic            last;
    logic            valid;
  } packer_stage_t;

endpackage

// File: rtl/stream_packer_if.sv
// Keep-masked element stream: N elements per beat with valid/ready handshake.
interface stream_packer_if #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 4
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/stream_packer_compact_stage.sv
// One level of the compaction network: element LEVEL moves down to slot
// `count` when kept. Optionally registered under the global pipeline enable.
module stream_packer_compact_stage
  import stream_packer_pkg::*;
#(
  parameter type stage_t      = packer_stage_t,
  parameter int  NUM_ELEMENTS = 4,
  parameter int  LEVEL        = 0,
  parameter bit  REGISTER     = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t stage_in,
  output stage_t stage_out
);
  localparam int CW = cnt_width(NUM_ELEMENTS);

  stage_t nxt;

  // Slots 0..LEVEL end up holding the contiguous keep mask of the survivors.
  always_comb begin
    nxt = stage_in;
    if (stage_in.keep[LEVEL]) begin
      for (int j = 0; j <= LEVEL; j++)
        if (j == int'(stage_in.count)) nxt.data[j] = stage_in.data[LEVEL];
      nxt.count = stage_in.count + CW'(1);
    end
    for (int j = 0; j <= LEVEL; j++) nxt.keep[j] = (j < int'(nxt.count));
  end

  if (REGISTER) begin : g_reg
    stage_t q;
    logic   q_vld;
    logic   unused_q_vld;

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  q_vld <= 1'b0;
      else if (en) q_vld <= nxt.valid;

    always_ff @(posedge clk)
      if (en) q <= nxt;

    assign unused_q_vld = q.valid;

    always_comb begin
      stage_out       = q;
      stage_out.valid = q_vld;
    end
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en};
    assign stage_out  = nxt;
  end

endmodule

// File: rtl/stream_packer.sv
// Drops keep-deasserted elements and repacks survivors into full output beats;
// `last` flushes a partial beat. Define STREAM_PACKER_SKID_EN for a 2-entry input skid.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter type data_t          = logic [7:0],
  parameter int  NUM_ELEMENTS    = 4,
  parameter int  REGISTER_LEVELS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_packer_if.slave  in,
  stream_packer_if.master out
);
  localparam int N  = NUM_ELEMENTS;
  localparam int CW = cnt_width(N);
  localparam int AW = cnt_width(2 * N);

  typedef struct packed {
    data_t [N-1:0] data;
    logic  [N-1:0] keep;
    logic  [CW-1:0] count;
    logic          last;
    logic          valid;
  } lvl_t;

  lvl_t stg [N+1];
  lvl_t tail;
  logic en, acc_take, fire, full, flush;

  logic [AW-1:0]       cnt, cnt_pop, cnt_nxt;
  data_t [2*N-1:0]     acc_buf, buf_pop, buf_nxt;
  logic  [N-1:0]       keep_c;

`ifdef STREAM_PACKER_SKID_EN
  typedef struct packed {
    data_t [N-1:0] data;
    logic  [N-1:0] keep;
    logic          last;
  } skid_ent_t;

  skid_ent_t skid [2];
  skid_ent_t in_ent;
  logic [1:0] skid_cnt, skid_cnt_nxt;
  logic skid_push, skid_pop, ready_q;

  assign in_ent       = '{data: in.data, keep: in.keep, last: in.last};
  assign skid_push    = in.valid && ready_q;
  assign skid_pop     = (skid_cnt != 2'd0) && en;
  assign skid_cnt_nxt = skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
  assign in.ready     = ready_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skid_cnt <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      skid_cnt <= skid_cnt_nxt;
      ready_q  <= (skid_cnt_nxt != 2'd2);
    end

  // Head lives in slot 0; a push lands just behind whatever survives the pop.
  always_ff @(posedge clk) begin
    if (skid_pop) skid[0] <= skid[1];
    if (skid_push) begin
      if ((skid_cnt - {1'b0, skid_pop}) == 2'd0) skid[0] <= in_ent;
      else                                       skid[1] <= in_ent;
    end
  end

  assign stg[0] = '{data: skid[0].data, keep: skid[0].keep, count: '0,
                    last: skid[0].last, valid: (skid_cnt != 2'd0)};
`else
  assign in.ready = en && rst_n;
  assign stg[0]   = '{data: in.data, keep: in.keep, count: '0,
                      last: in.last, valid: in.valid};
`endif

  for (genvar i = 0; i < N; i++) begin : g_lvl
    stream_packer_compact_stage #(
      .stage_t      (lvl_t),
      .NUM_ELEMENTS (N),
      .LEVEL        (i),
      .REGISTER     (level_registered(N, REGISTER_LEVELS, i))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .stage_in  (stg[i]),
      .stage_out (stg[i+1])
    );
  end

  assign tail = stg[N];

  assign full      = (cnt >= AW'(N));
  assign out.valid = full || flush;
  assign fire      = out.valid && out.ready;
  assign acc_take  = tail.valid && !flush && (!full || fire);
  assign en        = !tail.valid || acc_take;

  // Pop first, then append the compacted tail behind what remains.
  always_comb begin
    buf_pop = acc_buf;
    cnt_pop = cnt;
    if (fire) begin
      for (int j = 0; j < N; j++) buf_pop[j] = acc_buf[j+N];
      cnt_pop = full ? cnt - AW'(N) : '0;
    end
    buf_nxt = buf_pop;
    cnt_nxt = cnt_pop;
    if (acc_take) begin
      for (int j = 0; j < 2 * N; j++)
        for (int k = 0; k < N; k++)
          if (tail.keep[k] && (j == int'(cnt_pop) + k)) buf_nxt[j] = tail.data[k];
      cnt_nxt = cnt_pop + AW'(tail.count);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      flush <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (acc_take && tail.last)  flush <= 1'b1;
      else if (fire && out.last)  flush <= 1'b0;
    end

  always_ff @(posedge clk)
    acc_buf <= buf_nxt;

  always_comb begin
    keep_c = '0;
    for (int j = 0; j < N; j++) keep_c[j] = full || (j < int'(cnt));
  end

  assign out.data = acc_buf[N-1:0];
  assign out.keep = keep_c;
  assign out.last = flush && (cnt <= AW'(N));

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer (N=4, L=2): directed beats, expected
// output beats queued up front, a negedge monitor pops and compares.
module tb_stream_packer;
  localparam int N = 4;
  localparam int L = 2;
  typedef logic [7:0] elem_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  beat_t exp_q[$];

  stream_packer_if #(.data_t(elem_t), .NUM_ELEMENTS(N)) in_if ();
  stream_packer_if #(.data_t(elem_t), .NUM_ELEMENTS(N)) out_if ();

  stream_packer #(.data_t(elem_t), .NUM_ELEMENTS(N), .REGISTER_LEVELS(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_if),
    .out   (out_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    exp_q.push_back(b);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int acc_c);
    int guard;
    guard = 0;
    in_if.data = d; in_if.keep = k; in_if.last = l; in_if.valid = 1'b1;
    @(negedge clk);
    while (!in_if.ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_if.ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: data=%0h never accepted", d);
    end
    acc_c = cyc;
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  beat_t       mon_e;
  logic [31:0] mon_mask;
  logic        stall_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) chk("stall_hold_valid", out_if.valid, 1);
      if (out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: data=%0h keep=%0h last=%0b", out_if.data, out_if.keep, out_if.last);
        end else begin
          mon_e = exp_q.pop_front();
          for (int k = 0; k < N; k++) mon_mask[k*8 +: 8] = {8{mon_e.keep[k]}};
          chk("out_keep", out_if.keep, mon_e.keep);
          chk("out_last", out_if.last, mon_e.last);
          chk("out_data", out_if.data & mon_mask, mon_e.data & mon_mask);
        end
      end
      stall_q <= out_if.valid && !out_if.ready;
    end else begin
      stall_q <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int ta, tdummy, t_first;

  initial begin
    in_if.valid = 1'b0; in_if.data = '0; in_if.keep = '0; in_if.last = 1'b0;
    out_if.ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_keep",  out_if.keep,  0);
    chk("rst_out_last",  out_if.last,  0);
    chk("rst_in_ready",  in_if.ready,  0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_if.ready, 1);
    @(posedge clk); #1 out_if.ready = 1'b1;

    // Full beats, latency of first output
    push_exp(32'hA3A2A1A0, 4'hf, 1'b0);
    push_exp(32'hB3B2B1B0, 4'hf, 1'b0);
    push_exp(32'hC3C2C1C0, 4'hf, 1'b1);
    t_first = -1;
    fork
      begin
        send(32'hA3A2A1A0, 4'hf, 1'b0, ta);
        send(32'hB3B2B1B0, 4'hf, 1'b0, tdummy);
        send(32'hC3C2C1C0, 4'hf, 1'b1, tdummy);
      end
      begin
        for (int i = 0; i < 30 && !out_if.valid; i++) @(negedge clk);
        t_first = cyc;
      end
    join
    chk("first_out_latency", t_first - ta, 3);
    wait_drain("drain_full");

    // Cross-beat repacking
    push_exp(32'hB3B1A2A0, 4'hf, 1'b1);
    send(32'hA3A2A1A0, 4'b0101, 1'b0, tdummy);
    send(32'hB3B2B1B0, 4'b1010, 1'b1, tdummy);
    wait_drain("drain_repack");

    // Split flush (6 survivors) with an empty non-last beat in between
    push_exp(32'h30121110, 4'hf, 1'b0);
    push_exp(32'h00003231, 4'b0011, 1'b1);
    send(32'h13121110, 4'b0111, 1'b0, tdummy);
    send(32'h23222120, 4'b0000, 1'b0, tdummy);
    send(32'h33323130, 4'b0111, 1'b1, tdummy);
    wait_drain("drain_split");

    // Empty last
    push_exp(32'h00000000, 4'b0000, 1'b1);
    send(32'hDEADBEEF, 4'b0000, 1'b1, tdummy);
    wait_drain("drain_empty");

    // Backpressure
    for (int i = 0; i < 8; i++) push_exp(32'h01010101 * (i + 1), 4'hf, i == 7);
    out_if.ready = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(32'h01010101 * (i + 1), 4'hf, i == 7, tdummy);
      begin
        repeat (10) @(negedge clk);
        chk("bp_in_ready_low", in_if.ready, 0);
        chk("bp_out_valid",    out_if.valid, 1);
        @(posedge clk); #1 out_if.ready = 1'b1;
      end
    join
    wait_drain("drain_bp");

    // Reset mid-operation with cnt = 3 and a pending flush
    out_if.ready = 1'b0;
    send(32'h77665544, 4'b0111, 1'b1, tdummy);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", out_if.valid, 1);
    chk("pre_rst_keep",  out_if.keep,  4'b0111);
    chk("pre_rst_last",  out_if.last,  1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_if.valid, 0);
    chk("midrst_out_keep",  out_if.keep,  0);
    chk("midrst_in_ready",  in_if.ready,  0);
    @(posedge clk); #1 rst_n = 1'b1; out_if.ready = 1'b1;
    push_exp(32'h8C8B8A89, 4'hf, 1'b1);
    send(32'h8C8B8A89, 4'hf, 1'b1, tdummy);
    wait_drain("drain_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
